// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues one data-memory request per load/store,
// stalls the pipeline until ack or timeout, and produces the MEM/WB register.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic [31:0] AluResult_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  Rd_in,
    output logic        Stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] AluResult_out,
    output logic [4:0]  Rd_out,
    output logic        MisalignErr_out,
    output logic        TimeoutErr_out
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_wait_cnt;
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic        r_hold_regwrite;
    logic        r_hold_memtoreg;
    logic [31:0] r_hold_alu;
    logic [4:0]  r_hold_rd;
    logic        r_hold_is_read;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic [31:0] r_readdata;
    logic [31:0] r_alu;
    logic [4:0]  r_rd;
    logic        r_misalign;
    logic        r_timeout;

    logic        w_memop;
    logic        w_aligned;
    logic        w_cnt_last;

    assign w_memop    = MemRead_in | MemWrite_in;
    assign w_aligned  = (AluResult_in[1:0] == 2'b00);
    assign w_cnt_last = (r_wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        Stall_out    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop && w_aligned) begin
                    w_next_state = ST_WAIT;
                    Stall_out    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem_ack || w_cnt_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    Stall_out = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // WB outputs default to a bubble every edge; only a consumed ALU op or a
    // completed memory access overrides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt      <= '0;
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_dmem_addr     <= '0;
            r_dmem_wdata    <= '0;
            r_hold_regwrite <= 1'b0;
            r_hold_memtoreg <= 1'b0;
            r_hold_alu      <= '0;
            r_hold_rd       <= '0;
            r_hold_is_read  <= 1'b0;
            r_regwrite      <= 1'b0;
            r_memtoreg      <= 1'b0;
            r_readdata      <= '0;
            r_alu           <= '0;
            r_rd            <= '0;
            r_misalign      <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_readdata <= '0;
            r_alu      <= '0;
            r_rd       <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_memop) begin
                        r_regwrite <= RegWrite_in;
                        r_memtoreg <= MemToReg_in;
                        r_alu      <= AluResult_in;
                        r_rd       <= Rd_in;
                    end else if (w_aligned) begin
                        r_dmem_req      <= 1'b1;
                        r_dmem_we       <= MemWrite_in;
                        r_dmem_addr     <= AluResult_in;
                        r_dmem_wdata    <= WriteData_in;
                        r_wait_cnt      <= '0;
                        r_hold_regwrite <= RegWrite_in;
                        r_hold_memtoreg <= MemToReg_in;
                        r_hold_alu      <= AluResult_in;
                        r_hold_rd       <= Rd_in;
                        r_hold_is_read  <= MemRead_in & ~MemWrite_in;
                    end else begin
                        r_misalign <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_regwrite <= r_hold_regwrite;
                        r_memtoreg <= r_hold_memtoreg;
                        r_alu      <= r_hold_alu;
                        r_rd       <= r_hold_rd;
                        r_readdata <= r_hold_is_read ? dmem_rdata : 32'd0;
                    end else if (w_cnt_last) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                default: r_dmem_req <= 1'b0;
            endcase
        end
    end

    assign dmem_req        = r_dmem_req;
    assign dmem_we         = r_dmem_we;
    assign dmem_addr       = r_dmem_addr;
    assign dmem_wdata      = r_dmem_wdata;
    assign RegWrite_out    = r_regwrite;
    assign MemToReg_out    = r_memtoreg;
    assign ReadData_out    = r_readdata;
    assign AluResult_out   = r_alu;
    assign Rd_out          = r_rd;
    assign MisalignErr_out = r_misalign;
    assign TimeoutErr_out  = r_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: per-instruction transaction model
// predicts stall count, request cycles, MEM/WB result and error pulses.
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in;
    logic [31:0] AluResult_in, WriteData_in;
    logic [4:0]  Rd_in;
    logic        Stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        RegWrite_out, MemToReg_out;
    logic [31:0] ReadData_out, AluResult_out;
    logic [4:0]  Rd_out;
    logic        MisalignErr_out, TimeoutErr_out;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
        .AluResult_in(AluResult_in), .WriteData_in(WriteData_in), .Rd_in(Rd_in),
        .Stall_out(Stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .ReadData_out(ReadData_out), .AluResult_out(AluResult_out), .Rd_out(Rd_out),
        .MisalignErr_out(MisalignErr_out), .TimeoutErr_out(TimeoutErr_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [138:0] reg_outs();
        return {dmem_req, dmem_we, dmem_addr, dmem_wdata, RegWrite_out, MemToReg_out,
                ReadData_out, AluResult_out, Rd_out, MisalignErr_out, TimeoutErr_out};
    endfunction

    // Presents one instruction (called just after a rising edge), answers the
    // memory ack_at WAIT cycles after dmem_req rises (-1 = never), and checks
    // the result one edge after the instruction is consumed.
    task automatic do_instr(input string name, input logic mr, input logic mw,
                            input logic m2r, input logic rw, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [4:0] rd,
                            input int ack_at, input logic [31:0] rdata);
        logic [70:0] exp_wb;
        logic [70:0] got_wb;
        logic [1:0]  exp_err;
        int exp_stalls, exp_reqs;
        int stalls = 0, reqs = 0, cyc = 0, hold_bad = 0, err_bad = 0;
        bit done = 0;
        MemRead_in   = mr;
        MemWrite_in  = mw;
        MemToReg_in  = m2r;
        RegWrite_in  = rw;
        AluResult_in = addr;
        WriteData_in = wd;
        Rd_in        = rd;

        if (!(mr || mw)) begin
            exp_stalls = 0; exp_reqs = 0; exp_err = 2'b00;
            exp_wb = {rw, m2r, 32'd0, addr, rd};
        end else if (addr[1:0] != 2'b00) begin
            exp_stalls = 0; exp_reqs = 0; exp_err = 2'b10;
            exp_wb = '0;
        end else if (ack_at >= 0 && ack_at < TO) begin
            exp_stalls = 1 + ack_at; exp_reqs = ack_at + 1; exp_err = 2'b00;
            exp_wb = {rw, m2r, (mr && !mw) ? rdata : 32'd0, addr, rd};
        end else begin
            exp_stalls = TO; exp_reqs = TO; exp_err = 2'b01;
            exp_wb = '0;
        end

        while (!done && cyc < 64) begin
            @(negedge clk);
            if (cyc > 0 && (MisalignErr_out || TimeoutErr_out)) err_bad++;
            if (dmem_req) begin
                reqs++;
                if (dmem_we !== mw || dmem_addr !== addr || dmem_wdata !== wd) hold_bad++;
                dmem_ack   = (reqs - 1 == ack_at);
                dmem_rdata = rdata;
            end else begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            #1;
            if (Stall_out) stalls++;
            else done = 1;
            cyc++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s consume: not consumed within %0d cycles", name, cyc);
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;

        total++;
        if (stalls != exp_stalls) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
        end
        total++;
        if (reqs != exp_reqs) begin
            bad++;
            $display("FAIL %s req_cycles: got %0d expected %0d", name, reqs, exp_reqs);
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL %s req_fields: %0d cycles with we/addr/wdata not %0b/%h/%h",
                     name, hold_bad, mw, addr, wd);
        end
        total++;
        if (err_bad != 0) begin
            bad++;
            $display("FAIL %s stray_err: error pulse seen in %0d stall cycles, expected 0", name, err_bad);
        end
        got_wb = {RegWrite_out, MemToReg_out, ReadData_out, AluResult_out, Rd_out};
        total++;
        if (got_wb !== exp_wb) begin
            bad++;
            $display("FAIL %s wb: got rw=%b m2r=%b rdata=%h alu=%h rd=%0d expected rw=%b m2r=%b rdata=%h alu=%h rd=%0d",
                     name, got_wb[70], got_wb[69], got_wb[68:37], got_wb[36:5], got_wb[4:0],
                     exp_wb[70], exp_wb[69], exp_wb[68:37], exp_wb[36:5], exp_wb[4:0]);
        end
        total++;
        if ({MisalignErr_out, TimeoutErr_out} !== exp_err) begin
            bad++;
            $display("FAIL %s err_pulse: got mis/to=%b%b expected %b",
                     name, MisalignErr_out, TimeoutErr_out, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in} = '0;
        AluResult_in = '0; WriteData_in = '0; Rd_in = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #12;
        total++;
        if (reg_outs() !== '0 || Stall_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got outs=%h stall=%b expected 0", reg_outs(), Stall_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        do_instr("alu_op", 0, 0, 0, 1, 32'h0000_0010, 32'h0, 5'd5, -1, 32'h0);
        do_instr("load_ack3", 1, 0, 1, 1, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
        do_instr("store_ack1", 0, 1, 0, 0, 32'h0000_0204, 32'h1234_5678, 5'd0, 1, 32'hFFFF_FFFF);
        do_instr("misalign_load", 1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd3, -1, 32'h0);
        do_instr("timeout_load", 1, 0, 1, 1, 32'h0000_0300, 32'h0, 5'd4, -1, 32'h0);
        do_instr("ack_last_cycle", 1, 0, 1, 1, 32'h0000_0304, 32'h0, 5'd6, TO - 1, 32'hCAFE_F00D);
        do_instr("read_and_write", 1, 1, 1, 1, 32'h0000_0408, 32'hA5A5_A5A5, 5'd8, 0, 32'h1111_2222);
    endtask

    task automatic test_back_to_back();
        do_instr("b2b_load0", 1, 0, 1, 1, 32'h0000_0500, 32'h0, 5'd10, 0, 32'h0BAD_0001);
        do_instr("b2b_load1", 1, 0, 1, 1, 32'h0000_0504, 32'h0, 5'd11, 0, 32'h0BAD_0002);
        do_instr("b2b_alu", 0, 0, 0, 1, 32'h0000_0777, 32'h0, 5'd12, -1, 32'h0);
    endtask

    task automatic test_reset_mid_wait();
        MemRead_in = 1'b1; MemWrite_in = 1'b0; MemToReg_in = 1'b1; RegWrite_in = 1'b1;
        AluResult_in = 32'h0000_0600; WriteData_in = '0; Rd_in = 5'd13;
        dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (dmem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_wait_req: got dmem_req=%b expected 1", dmem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (reg_outs() !== '0) begin
            bad++;
            $display("FAIL rst_async_clear: got outs=%h expected 0", reg_outs());
        end
        {MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in} = '0;
        AluResult_in = '0; Rd_in = '0;
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (reg_outs() !== '0) begin
            bad++;
            $display("FAIL rst_late_ack: got outs=%h expected 0", reg_outs());
        end
        dmem_ack = 1'b0;
        do_instr("alu_after_rst", 0, 0, 0, 1, 32'h0000_0042, 32'h0, 5'd9, -1, 32'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int kind;
            int ack_at;
            logic [31:0] a;
            logic mr, mw;
            kind = $urandom_range(0, 3);
            a = $urandom;
            mr = 1'b0; mw = 1'b0;
            if (kind == 0) begin
                a = a;
            end else begin
                case ($urandom_range(0, 2))
                    0: mr = 1'b1;
                    1: mw = 1'b1;
                    default: begin mr = 1'b1; mw = 1'b1; end
                endcase
                if (kind == 1) a[1:0] = 2'($urandom_range(1, 3));
                else a[1:0] = 2'b00;
            end
            ack_at = $urandom_range(0, TO + 2);
            if (ack_at > TO - 1) ack_at = -1;
            else if ($urandom_range(0, 1) == 1) ack_at = ack_at % 4;
            do_instr($sformatf("rand%0d", n), mr, mw, 1'($urandom), 1'($urandom), a,
                     $urandom, 5'($urandom), ack_at, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles in WAIT without dmem_ack before abort (range 2..16).
REQ-002 One clock; reset is asynchronous and active-low; ports: clk (input, 1, rising-edge clock), rst_n (input, 1, async active-low reset).
REQ-003 MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in: input, 1 each, control from EX/MEM register.
REQ-004 AluResult_in: input, 32, effective address or ALU result; WriteData_in: input, 32, store data; Rd_in: input, 5, destination register.
REQ-005 Stall_out: output, 1, holds EX/MEM register and upstream stages when 1.
REQ-006 dmem_req, dmem_we: output, 1 each, memory request and write enable; dmem_addr, dmem_wdata: output, 32 each.
REQ-007 dmem_rdata: input, 32, read data, valid with dmem_ack; dmem_ack: input, 1, request completion.
REQ-008 RegWrite_out, MemToReg_out: output, 1 each; ReadData_out, AluResult_out: output, 32 each; Rd_out: output, 5; all MEM/WB side.
REQ-009 MisalignErr_out, TimeoutErr_out: output, 1 each, single-cycle error pulses.

Function
REQ-010 FSM states: IDLE, WAIT; memop = MemRead_in | MemWrite_in; aligned = (AluResult_in[1:0] == 2'b00).
REQ-011 Stall_out SHALL be combinational: (IDLE & memop & aligned) | (WAIT & ~dmem_ack & ~(wait_cnt == TIMEOUT-1)).
REQ-012 An instruction is consumed at the rising edge where Stall_out = 0; inputs are ignored while Stall_out = 1.
REQ-013 IDLE, ~memop: at the edge, register RegWrite, MemToReg, AluResult, Rd to outputs; ReadData_out <= 0; latency 1 cycle.
REQ-014 IDLE, memop & aligned: at the edge, enter WAIT; register dmem_req=1, dmem_we=MemWrite_in, dmem_addr=AluResult_in, dmem_wdata=WriteData_in; wait_cnt <= 0; WB outputs <= bubble (all 0).
REQ-015 MemRead_in and MemWrite_in both 1: treat as a write; ReadData_out SHALL be 0 for that instruction.
REQ-016 IDLE, memop & ~aligned: no request, no stall; WB outputs <= bubble; MisalignErr_out = 1 for exactly the next cycle.
REQ-017 WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata SHALL hold constant until ack or timeout; wait_cnt increments each cycle without ack, saturating at TIMEOUT-1.
REQ-018 WAIT & dmem_ack: at the edge, dmem_req <= 0; ReadData_out <= dmem_rdata (read) or 0 (write); other WB outputs <= held inputs; return to IDLE.
REQ-019 WAIT, ~dmem_ack, wait_cnt == TIMEOUT-1: at the edge, dmem_req <= 0, WB outputs <= bubble, TimeoutErr_out = 1 for the next cycle, return to IDLE.
REQ-020 dmem_ack on the final timeout cycle SHALL win: normal completion, no TimeoutErr_out.
REQ-021 dmem_ack while in IDLE or while dmem_req = 0 SHALL be ignored.
REQ-022 Error pulses SHALL deassert after one cycle, never overlap, and SHALL NOT stall the pipeline.
REQ-023 Back-to-back memops: each SHALL wait in IDLE with Stall_out = 1 for one cycle before entering WAIT; minimum memop latency is 2 cycles.

Reset
REQ-024 rst_n = 0 SHALL immediately, independent of clk, force IDLE, wait_cnt = 0, and set all outputs to 0, including dmem_req, the error pulses and the WB outputs.
REQ-025 Reset asserted in WAIT SHALL abandon the request with no error pulse; a later dmem_ack SHALL be ignored.
REQ-026 After rst_n rises, the first rising edge SHALL evaluate in IDLE with normal rules.

Verification
REQ-027 ALU op RegWrite_in=1, AluResult_in=0x0000_0010, Rd_in=5 -> next cycle RegWrite_out=1, AluResult_out=0x10, Rd_out=5, Stall_out never 1.
REQ-028 Load at addr 0x100, ack with rdata=0xDEADBEEF 3 cycles after dmem_req rises -> Stall_out high 4 cycles total; ReadData_out=0xDEADBEEF, MemToReg_out=1.
REQ-029 Store at addr 0x204, WriteData_in=0x12345678, ack after 1 cycle -> dmem_we=1, dmem_wdata=0x12345678, RegWrite_out=0, single write.
REQ-030 Load at addr 0x102 -> no dmem_req, MisalignErr_out pulses 1 cycle, RegWrite_out=0, no stall.
REQ-031 Load with no ack, TIMEOUT=16 -> dmem_req high exactly 16 cycles, TimeoutErr_out pulses once, WB bubble, IDLE; repeat with ack on cycle 16 -> normal completion.
REQ-032 rst_n low mid-WAIT with a late ack -> all outputs 0 asynchronously; ack ignored; next ALU op completes with 1-cycle latency.
